// File: rtl/ram_bus_responder_if.sv
// Requester <-> RAM responder handshake signals (strobes, address, ready, error flags).
// The shared data bus stays outside because it is a multi-driver tristate net; RAM_PARITY_EN adds par_err.
interface ram_bus_responder_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] addr;
  logic              rd_ram;
  logic              wrt_ram;
  logic              ready;
  logic              req_err;
`ifdef RAM_PARITY_EN
  logic              par_err;

  modport master (output addr, rd_ram, wrt_ram, input ready, req_err, par_err);
  modport slave  (input addr, rd_ram, wrt_ram, output ready, req_err, par_err);
`else
  modport master (output addr, rd_ram, wrt_ram, input ready, req_err);
  modport slave  (input addr, rd_ram, wrt_ram, output ready, req_err);
`endif
endinterface

// File: rtl/ram_bus_responder.sv
// RAM-side responder on the shared 8-bit tristate bus; ready rises LATENCY cycles after acceptance.
// 4-phase handshake: the requester holds its strobe until ready, ready drops one edge after the strobe.
// Optional stored even-parity bit and par_err output under `RAM_PARITY_EN.
module ram_bus_responder #(
  parameter int ADDR_W  = 4,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_bus_responder_if.slave bus,
  inout  wire  [7:0]         data
);

`ifdef RAM_PARITY_EN
  localparam int WORD_W = 9;
`else
  localparam int WORD_W = 8;
`endif
  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          cnt;
  logic [3:0]          cnt_nxt;
  logic                op_rd;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wdata_q;
  logic [7:0]          rdata_q;
  logic                ready_q;
  logic                req_err_q;
  logic                drive_q;
  logic                accept;
  logic                conflict;
  logic                commit_wr;
  logic                load_rd;
  logic                op_strobe;
  logic [WORD_W-1:0]   mem [DEPTH];
  logic [WORD_W-1:0]   rd_word;
  logic [WORD_W-1:0]   wr_word;

  assign op_strobe = op_rd ? bus.rd_ram : bus.wrt_ram;
  assign rd_word   = mem[addr_q];

`ifdef RAM_PARITY_EN
  logic par_err_q;

  assign wr_word     = {^wdata_q, wdata_q};
  assign bus.par_err = par_err_q;
`else
  assign wr_word     = wdata_q;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    conflict  = 1'b0;
    commit_wr = 1'b0;
    load_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_ram && bus.wrt_ram) begin
          conflict = 1'b1;
        end else if (bus.rd_ram || bus.wrt_ram) begin
          accept    = 1'b1;
          cnt_nxt   = LAT_M1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Strobe withdrawal wins over counter expiry: an aborted write never commits.
        if (!op_strobe) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit_wr = !op_rd;
          load_rd   = op_rd;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (!op_strobe) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_rd     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      ready_q   <= 1'b0;
      req_err_q <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_err_q <= conflict;
      ready_q   <= (state_nxt == RESP);
      // op_rd is stable from WAIT into RESP, so the drive enable is a clean registered signal.
      drive_q   <= (state_nxt == RESP) && op_rd;
      if (accept) begin
        addr_q <= bus.addr;
        op_rd  <= bus.rd_ram;
        if (!bus.rd_ram) begin
          wdata_q <= data;
        end
      end
      if (load_rd) begin
        rdata_q <= rd_word[7:0];
      end
    end
  end

`ifdef RAM_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (load_rd) begin
      par_err_q <= ^rd_word;
    end else if (state_nxt != RESP) begin
      par_err_q <= 1'b0;
    end
  end
`endif

  // Storage has no reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && commit_wr) begin
      mem[addr_q] <= wr_word;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.req_err = req_err_q;
  assign data        = drive_q ? rdata_q : 8'hzz;

endmodule
